// File: rtl/ttl_jk_pkg.sv
// Shared types for the J-K register writer: FSM states, J/K drive codes and a width helper.
// The optional toggle encoding is selected with the TTL_JK_TOGGLE_ENC_EN macro (see ttl_jk_encoder).
package ttl_jk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    FALL,
    RISE,
    CHECK,
    FINISH,
    FAIL
  } state_t;

  // {J,K} drive codes for one flip-flop
  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] SET  = 2'b10;
  localparam logic [1:0] RST  = 2'b01;
  localparam logic [1:0] TGL  = 2'b11;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ttl_jk_encoder.sv
// Combinational per-bit J/K generation. Default build: set/reset encoding from the target.
// With TTL_JK_TOGGLE_ENC_EN defined: toggle only the masked bits whose readback differs from the target.
module ttl_jk_encoder
  import ttl_jk_pkg::*;
#(
  parameter int BLOCKS = 2
) (
  input  logic [BLOCKS-1:0] data,
  input  logic [BLOCKS-1:0] mask,
  input  logic [BLOCKS-1:0] q_fb,
  output logic [BLOCKS-1:0] j,
  output logic [BLOCKS-1:0] k
);

  for (genvar gi = 0; gi < BLOCKS; gi++) begin : g_bit
    logic [1:0] code;

    always_comb begin
      code = HOLD;
      if (mask[gi]) begin
`ifdef TTL_JK_TOGGLE_ENC_EN
        code = (q_fb[gi] != data[gi]) ? TGL : HOLD;
`else
        code = data[gi] ? SET : RST;
`endif
      end
    end

    assign j[gi] = code[1];
    assign k[gi] = code[0];
  end

`ifndef TTL_JK_TOGGLE_ENC_EN
  logic unused_q_fb;
  assign unused_q_fb = ^q_fb;
`endif

endmodule

// File: rtl/ttl_jk_writer.sv
// Writes a target value into a bank of negedge J-K flip-flops: drive J/K, pulse Jk_clk low,
// read Q back and retry on mismatch. Build option TTL_JK_TOGGLE_ENC_EN selects toggle encoding.
module ttl_jk_writer
  import ttl_jk_pkg::*;
#(
  parameter int BLOCKS       = 2,
  parameter int SETUP_CYCLES = 1,
  parameter int HOLD_CYCLES  = 1,
  parameter int MAX_RETRY    = 2
) (
  input  logic              Clk,
  input  logic              Reset_bar,
  input  logic              Req,
  input  logic [BLOCKS-1:0] Data,
  input  logic [BLOCKS-1:0] Mask,
  output logic              Ready,
  output logic              Done,
  output logic              Error,
  output logic              Error_flag,
  output logic [BLOCKS-1:0] J,
  output logic [BLOCKS-1:0] K,
  output logic              Jk_clk,
  input  logic [BLOCKS-1:0] Q_fb
);

  localparam int RW = cnt_width(MAX_RETRY + 1);
  localparam int STRETCH_MAX = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int SW = cnt_width(STRETCH_MAX);

  state_t            state_reg, state_next;
  logic [SW-1:0]     stretch_reg, stretch_next;
  logic [RW-1:0]     retry_reg, retry_next;
  logic [BLOCKS-1:0] data_reg, mask_reg;
  logic [BLOCKS-1:0] j_reg, j_next, k_reg, k_next;
  logic              ready_reg, ready_next, done_reg, done_next, error_reg, error_next;
  logic              flag_reg, flag_next, jk_clk_reg, jk_clk_next;
  logic              accept, load_jk, drive_phase;
  logic [BLOCKS-1:0] enc_data, enc_mask, enc_j, enc_k;

  assign accept = Req && ready_reg;

  // On the accept edge the latched copies are not yet valid, so encode straight from the inputs.
  assign enc_data = accept ? Data : data_reg;
  assign enc_mask = accept ? Mask : mask_reg;

  ttl_jk_encoder #(.BLOCKS(BLOCKS)) u_encoder (
    .data (enc_data),
    .mask (enc_mask),
    .q_fb (Q_fb),
    .j    (enc_j),
    .k    (enc_k)
  );

  always_ff @(posedge Clk or negedge Reset_bar) begin
    if (!Reset_bar) begin
      state_reg   <= IDLE;
      stretch_reg <= '0;
      retry_reg   <= '0;
      data_reg    <= '0;
      mask_reg    <= '0;
      j_reg       <= '0;
      k_reg       <= '0;
      ready_reg   <= 1'b1;
      done_reg    <= 1'b0;
      error_reg   <= 1'b0;
      flag_reg    <= 1'b0;
      jk_clk_reg  <= 1'b1;
    end else begin
      state_reg   <= state_next;
      stretch_reg <= stretch_next;
      retry_reg   <= retry_next;
      if (accept) begin
        data_reg <= Data;
        mask_reg <= Mask;
      end
      j_reg      <= j_next;
      k_reg      <= k_next;
      ready_reg  <= ready_next;
      done_reg   <= done_next;
      error_reg  <= error_next;
      flag_reg   <= flag_next;
      jk_clk_reg <= jk_clk_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    stretch_next = '0;
    retry_next   = retry_reg;
    case (state_reg)
      IDLE, FINISH, FAIL: begin
        state_next = IDLE;
        if (accept) begin
          state_next = (Mask == '0) ? FINISH : SETUP;
          retry_next = '0;
        end
      end
      SETUP: begin
        if (stretch_reg == SW'(SETUP_CYCLES - 1)) state_next = FALL;
        else stretch_next = stretch_reg + SW'(1);
      end
      FALL: begin
        if (stretch_reg == SW'(HOLD_CYCLES - 1)) state_next = RISE;
        else stretch_next = stretch_reg + SW'(1);
      end
      RISE: state_next = CHECK;
      CHECK: begin
        if ((Q_fb & mask_reg) == (data_reg & mask_reg)) begin
          state_next = FINISH;
        end else if (retry_reg < RW'(MAX_RETRY)) begin
          retry_next = retry_reg + RW'(1);
          state_next = SETUP;
        end else begin
          state_next = FAIL;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are a registered function of the next state; J/K are captured once per SETUP entry.
  always_comb begin
    load_jk     = (state_next == SETUP) && (state_reg != SETUP);
    drive_phase = (state_next == SETUP) || (state_next == FALL) || (state_next == RISE);
    ready_next  = (state_next == IDLE) || (state_next == FINISH) || (state_next == FAIL);
    done_next   = (state_next == FINISH);
    error_next  = (state_next == FAIL);
    jk_clk_next = (state_next != FALL);
    flag_next   = flag_reg;
    if (accept) flag_next = 1'b0;
    if (state_next == FAIL) flag_next = 1'b1;
    j_next = '0;
    k_next = '0;
    if (load_jk) begin
      j_next = enc_j;
      k_next = enc_k;
    end else if (drive_phase) begin
      j_next = j_reg;
      k_next = k_reg;
    end
  end

  assign Ready      = ready_reg;
  assign Done       = done_reg;
  assign Error      = error_reg;
  assign Error_flag = flag_reg;
  assign J          = j_reg;
  assign K          = k_reg;
  assign Jk_clk     = jk_clk_reg;

endmodule

// File: tb/tb_ttl_jk_writer.sv
// Scoreboard bench for ttl_jk_writer: a behavioural bank of negedge J-K flops, random writes
// (some with a stuck readback), an outcome model per write, and a decoupled monitor.
module tb_ttl_jk_writer;

  localparam int BLOCKS       = 2;
  localparam int SETUP_CYCLES = 1;
  localparam int HOLD_CYCLES  = 1;
  localparam int MAX_RETRY    = 2;
  localparam int ATTEMPT_CYC  = SETUP_CYCLES + HOLD_CYCLES + 2;

  logic              Clk = 1'b0;
  logic              Reset_bar = 1'b1;
  logic              Req = 1'b0;
  logic [BLOCKS-1:0] Data = '0;
  logic [BLOCKS-1:0] Mask = '0;
  logic              Ready, Done, Error, Error_flag, Jk_clk;
  logic [BLOCKS-1:0] J, K, Q_fb;

  logic [BLOCKS-1:0] bank_q = '0;
  logic              stuck = 1'b0;
  logic [BLOCKS-1:0] stuck_val = '0;
  logic [BLOCKS-1:0] model_q = '0;

  int tests = 0;
  int fails = 0;

  ttl_jk_writer #(
    .BLOCKS(BLOCKS), .SETUP_CYCLES(SETUP_CYCLES), .HOLD_CYCLES(HOLD_CYCLES), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .Clk(Clk), .Reset_bar(Reset_bar), .Req(Req), .Data(Data), .Mask(Mask),
    .Ready(Ready), .Done(Done), .Error(Error), .Error_flag(Error_flag),
    .J(J), .K(K), .Jk_clk(Jk_clk), .Q_fb(Q_fb)
  );

  always #5 Clk = ~Clk;

  // The flip-flop bank: 74112-style, commits on the falling edge of Jk_clk.
  always @(negedge Jk_clk) begin
    for (int i = 0; i < BLOCKS; i++) begin
      case ({J[i], K[i]})
        2'b10:   bank_q[i] <= 1'b1;
        2'b01:   bank_q[i] <= 1'b0;
        2'b11:   bank_q[i] <= ~bank_q[i];
        default: ;
      endcase
    end
  end

  assign Q_fb = stuck ? stuck_val : bank_q;

  typedef struct {
    bit                is_err;
    int                lat;
    int                falls;
    logic [BLOCKS-1:0] q_end;
    logic [BLOCKS-1:0] j;
    logic [BLOCKS-1:0] k;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Outcome of one write from the bank contents, target, mask and readback condition.
  function automatic exp_t model(input logic [BLOCKS-1:0] q, input logic [BLOCKS-1:0] d,
                                 input logic [BLOCKS-1:0] m, input bit stk,
                                 input logic [BLOCKS-1:0] f);
    exp_t e;
    logic [BLOCKS-1:0] fb;
    e.is_err = 1'b0;
    e.lat    = 1;
    e.falls  = 0;
    e.q_end  = q;
    e.j      = '0;
    e.k      = '0;
    if (m == '0) return e;
    fb = stk ? f : q;
`ifdef TTL_JK_TOGGLE_ENC_EN
    e.j = (fb ^ d) & m;
    e.k = e.j;
`else
    e.j = d & m;
    e.k = ~d & m;
`endif
    for (int a = 1; a <= MAX_RETRY + 1; a++) begin
      fb = stk ? f : q;
`ifdef TTL_JK_TOGGLE_ENC_EN
      q = q ^ ((fb ^ d) & m);
`else
      q = (q & ~m) | (d & m);
`endif
      e.falls = a;
      e.lat   = a * ATTEMPT_CYC + 1;
      fb = stk ? f : q;
      if ((fb & m) == (d & m)) break;
      if (a == MAX_RETRY + 1) e.is_err = 1'b1;
    end
    e.q_end = q;
    return e;
  endfunction

  task automatic issue(input logic [BLOCKS-1:0] d, input logic [BLOCKS-1:0] m,
                       input bit stk, input logic [BLOCKS-1:0] f);
    int n;
    exp_t e;
    n = 0;
    @(negedge Clk);
    while (!Ready && n < 200) begin
      @(negedge Clk);
      n++;
    end
    chk("ready_wait", Ready, 1);
    if (!Ready) return;
    stuck     = stk;
    stuck_val = f;
    Data      = d;
    Mask      = m;
    Req       = 1'b1;
    e = model(model_q, d, m, stk, f);
    @(posedge Clk);
    #1;
    Req  = 1'b0;
    Data = BLOCKS'($urandom);
    Mask = BLOCKS'($urandom);
    exp_q.push_back(e);
    model_q = e.q_end;
  endtask

  // Monitor: pops one expectation per write and checks it when Done or Error shows up.
  exp_t cur;
  bit   active = 1'b0;
  int   lat = 0;
  int   falls = 0;
  int   txn_no = 0;
  logic prev_jk = 1'b1;

  always @(negedge Clk) begin
    if (!Reset_bar) begin
      active  = 1'b0;
      exp_q.delete();
      prev_jk = 1'b1;
    end else begin
      if (active) lat++;
      else if (exp_q.size() > 0) begin
        cur    = exp_q.pop_front();
        active = 1'b1;
        lat    = 1;
        falls  = 0;
      end
      if (active) begin
        if (prev_jk && !Jk_clk) falls++;
        if (lat == 1) begin
          chk("j_first_setup", J, cur.j);
          chk("k_first_setup", K, cur.k);
        end
        if (Done || Error) begin
          chk("done", Done, !cur.is_err);
          chk("error", Error, cur.is_err);
          chk("latency", lat, cur.lat);
          chk("jk_clk_falls", falls, cur.falls);
          chk("bank_q", bank_q, cur.q_end);
          chk("error_flag", Error_flag, cur.is_err);
          chk("ready_at_end", Ready, 1);
          chk("jk_zero_at_end", {J, K}, 0);
          $display("[TB] txn %0d: %s lat=%0d falls=%0d bank_q=%b (model %s lat=%0d falls=%0d q=%b)",
                   txn_no, Done ? "done" : "error", lat, falls, bank_q,
                   cur.is_err ? "error" : "done", cur.lat, cur.falls, cur.q_end);
          txn_no++;
          active = 1'b0;
        end else if (lat > 100) begin
          chk("txn_timeout", lat, cur.lat);
          active = 1'b0;
        end
      end else if (Done || Error) begin
        chk("spurious_done_error", {Done, Error}, 0);
      end
      prev_jk = Jk_clk;
    end
  end

  initial begin
    int n;
    #1 Reset_bar = 1'b0;
    #2;
    chk("rst_ready", Ready, 1);
    chk("rst_done", Done, 0);
    chk("rst_error", Error, 0);
    chk("rst_error_flag", Error_flag, 0);
    chk("rst_jk", {J, K}, 0);
    chk("rst_jk_clk", Jk_clk, 1);
    repeat (2) @(negedge Clk);
    #2 Reset_bar = 1'b1;

    // Directed writes, then random ones (some with readback stuck).
    issue(2'b10, 2'b11, 1'b0, 2'b00);
    issue(2'b11, 2'b11, 1'b0, 2'b00);
    issue(2'b00, 2'b01, 1'b0, 2'b00);
    issue(2'b01, 2'b00, 1'b0, 2'b00);
    issue(2'b11, 2'b11, 1'b1, 2'b00);
    issue(2'b01, 2'b11, 1'b0, 2'b00);
    for (int t = 0; t < 40; t++) begin
      issue(BLOCKS'($urandom), BLOCKS'($urandom), ($urandom_range(0, 3) == 0), BLOCKS'($urandom));
    end

    // Abort a write while Jk_clk is low.
    issue(~model_q, 2'b11, 1'b0, 2'b00);
    n = 0;
    while (Jk_clk !== 1'b0 && n < 50) begin
      @(negedge Clk);
      n++;
    end
    chk("saw_jk_clk_low", Jk_clk, 0);
    #2 Reset_bar = 1'b0;
    #1;
    chk("abort_jk_clk", Jk_clk, 1);
    chk("abort_jk", {J, K}, 0);
    chk("abort_ready", Ready, 1);
    chk("abort_done_error", {Done, Error}, 0);
    repeat (2) @(negedge Clk);
    #2 Reset_bar = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge Clk);
      chk("post_abort_quiet", {Done, Error}, 0);
    end
    model_q = bank_q;
    issue(~model_q, 2'b11, 1'b0, 2'b00);

    n = 0;
    while ((exp_q.size() > 0 || active) && n < 200) begin
      @(negedge Clk);
      n++;
    end
    chk("drain", exp_q.size() + int'(active), 0);
    repeat (2) @(negedge Clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ttl_jk_writer.md
Name: ttl_jk_writer

Overview:
- Single-clock sequencer that writes a target value into a bank of negative-edge J-K flip-flops (ttl_74112-style parts).
- Per bit, it drives J/K, then generates one falling clock edge on the bank.
- It reads the Q outputs back and retries on mismatch.
- Writer side of the J-K register interface; sits between board-level control logic and the TTL flip-flop models.

Parameters:
- BLOCKS, 2, number of J-K flip-flops driven (width of the data/J/K/Q vectors).
- SETUP_CYCLES, 1, cycles J/K are stable with Jk_clk high before the falling edge (≥1).
- HOLD_CYCLES, 1, cycles Jk_clk is held low (≥1).
- MAX_RETRY, 2, extra write attempts after a readback mismatch (0 = no retry).

Ports:
- Clk  input  1  system clock, rising-edge.
- Reset_bar  input  1  asynchronous, active-low reset.
- Req  input  1  write request, sampled only while Ready=1.
- Data  input  BLOCKS  target Q value.
- Mask  input  BLOCKS  1 = bit is written, 0 = bit is held.
- Ready  output  1  idle, can accept Req.
- Done  output  1  one-cycle pulse: write verified.
- Error  output  1  one-cycle pulse: retries exhausted.
- Error_flag  output  1  sticky error, cleared by the next accepted Req.
- J  output  BLOCKS  J drive to the flip-flop bank.
- K  output  BLOCKS  K drive to the flip-flop bank.
- Jk_clk  output  1  shared clock to the bank; idles high; the falling edge commits.
- Q_fb  input  BLOCKS  Q readback from the bank, already in the Clk domain.

Behaviour:
- Clock and reset: one clock (Clk); reset is asynchronous and active-low (Reset_bar).
- Reset values: Ready=1, Done=0, Error=0, Error_flag=0, J=0, K=0, Jk_clk=1, retry count 0, state IDLE. Reset mid-operation aborts immediately. Jk_clk returning high is benign for negedge parts.
- All outputs are registered.
- IDLE: Req=1 with Ready=1 at edge T latches Data/Mask, clears Error_flag and retry count, drops Ready.
  - If Mask=0, go to FINISH with no Jk_clk pulse.
  - Otherwise go to SETUP.
- SETUP (SETUP_CYCLES): J/K driven per encoding, Jk_clk=1.
- FALL (HOLD_CYCLES): Jk_clk=0 (the falling edge occurs on entry); J/K unchanged.
- RISE (1 cycle): Jk_clk=1, J/K unchanged.
- CHECK (1 cycle): compare (Q_fb & Mask_l) with (Data_l & Mask_l).
  - Match: go to FINISH.
  - Mismatch and retry count < MAX_RETRY: increment the count, go to SETUP with re-encoded J/K.
  - Mismatch and retry count = MAX_RETRY: go to FAIL.
- FINISH: Done=1 for one cycle, J=K=0, Ready=1 in the same cycle, then IDLE.
- FAIL: Error=1 for one cycle, Error_flag=1, J=K=0, Ready=1, then IDLE.
- Nominal latency (defaults, no retry): Req accepted at edge T, Jk_clk falls after T+1, Done high in cycle T+4 to T+5.
- Encoding (default): masked-off bit gives J=0,K=0. Target 1 gives J=1,K=0. Target 0 gives J=0,K=1.
- Req while Ready=0 is ignored (no queue). Data/Mask changes after acceptance are ignored.
- J/K are only non-zero in SETUP/FALL/RISE.
- Retry count width is clog2(MAX_RETRY+1), minimum 1.

Optional Feature:
- Macro TTL_JK_TOGGLE_ENC_EN.
- Defined: encoding uses current Q_fb. A masked bit with Q_fb≠target gets J=K=1 (toggle); with Q_fb=target it gets J=K=0. Encoding is recomputed on each SETUP entry from Q_fb sampled that cycle.
- Undefined: set/reset encoding above.
- FSM, timing and verification are identical in both builds.

Decomposition:
- Package ttl_jk_pkg: FSM state enum (IDLE, SETUP, FALL, RISE, CHECK, FINISH, FAIL) and the J/K encoding constants (HOLD=2'b00, SET=2'b10, RST=2'b01, TGL=2'b11).
- Sub-module ttl_jk_encoder: combinational per-bit J/K generation from Data, Mask, Q_fb and the macro. The FSM, stretch counters and retry count stay in ttl_jk_writer.

Test Plan:
- Basic write: BLOCKS=2, bank models start with Q=2'b00; Req with Data=2'b10, Mask=2'b11 -> J=2'b10, K=2'b01; one Jk_clk falling edge; Done pulse at T+4; Q=2'b10; Error_flag=0.
- Masked hold: bank Q=2'b11; Data=2'b00, Mask=2'b01 -> J=2'b00, K=2'b01; bank ends at Q=2'b10; Done asserted.
- Empty mask: Mask=2'b00 -> no Jk_clk edge; Done pulse in the cycle after accept; J=K=0 throughout.
- Retry then fail: Q_fb forced to 2'b00, target 2'b11, MAX_RETRY=2 -> exactly 3 falling Jk_clk edges; one Error pulse; Error_flag=1; next accepted Req clears it.
- Reset mid-op: assert Reset_bar=0 during FALL -> Jk_clk=1, J=K=0, Ready=1 asynchronously; no Done/Error after release.
- Toggle build (TTL_JK_TOGGLE_ENC_EN): Q_fb=2'b01, Data=2'b10, Mask=2'b11 -> J=K=2'b11; Q becomes 2'b10; Done asserted.
